// File: rtl/filt_pkg.sv
// Shared defaults and fixed-point helpers for the filt_* chain.
// Helpers work on a 64-bit signed carrier so any supported width fits without wrap.
package filt_pkg;

   localparam int c_inp_width  = 24;
   localparam int c_oup_width  = 16;
   localparam int c_lsb_drop   = 6;
   localparam int c_dec_factor = 4;
   localparam int c_dec_phase  = 0;

   typedef logic signed [63:0] wide_t;

   // Round half up: add half an output LSB, then floor via arithmetic shift.
   function automatic wide_t rnd_half_up(input wide_t value, input int lsb_drop);
      wide_t bias;
      if (lsb_drop == 0) begin
         return value;
      end
      bias = wide_t'(1) <<< (lsb_drop - 1);
      return (value + bias) >>> lsb_drop;
   endfunction

   function automatic wide_t sat_max(input int width);
      return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t sat_min(input int width);
      return -sat_max(width) - wide_t'(1);
   endfunction

   function automatic wide_t sat_clamp(input wide_t value, input int width);
      if (value > sat_max(width)) begin
         return sat_max(width);
      end
      if (value < sat_min(width)) begin
         return sat_min(width);
      end
      return value;
   endfunction

   function automatic logic sat_ovf(input wide_t value, input int width);
      return (value > sat_max(width)) || (value < sat_min(width));
   endfunction

endpackage

// File: rtl/dsp_rnd_sat.sv
// Combinational round-half-up plus saturate with a clamp indicator.
// With gp_lsb_drop=0 it acts as a pure saturator.
module dsp_rnd_sat
   import filt_pkg::*;
#(
   parameter int gp_inp_width = c_inp_width,
   parameter int gp_oup_width = c_oup_width,
   parameter int gp_lsb_drop  = c_lsb_drop
) (
   input  logic signed [gp_inp_width-1:0] i_data,
   output logic signed [gp_oup_width-1:0] o_data,
   output logic                           o_ovf
);

   wide_t rnd_value;

   assign rnd_value = rnd_half_up(wide_t'(i_data), gp_lsb_drop);
   assign o_data    = gp_oup_width'(sat_clamp(rnd_value, gp_oup_width));
   assign o_ovf     = sat_ovf(rnd_value, gp_oup_width);

endmodule

// File: rtl/filt_dec_oup.sv
// Decimating output stage after filt_fir: keep one sample in M, round, saturate,
// emit a one-cycle valid strobe and a sticky overflow flag.
module filt_dec_oup
   import filt_pkg::*;
#(
   parameter int gp_inp_width  = c_inp_width,
   parameter int gp_oup_width  = c_oup_width,
   parameter int gp_lsb_drop   = c_lsb_drop,
   parameter int gp_dec_factor = c_dec_factor,
   parameter int gp_dec_phase  = c_dec_phase
) (
   input  logic                           i_clk,
   input  logic                           i_rst_an,
   input  logic                           i_ena,
   input  logic signed [gp_inp_width-1:0] i_data,
   input  logic                           i_clr_ovf,
   output logic signed [gp_oup_width-1:0] o_data,
   output logic                           o_valid,
   output logic                           o_ovf
);

   localparam int rnd_width = gp_inp_width - gp_lsb_drop + 1;
   localparam int cnt_width = (gp_dec_factor > 1) ? $clog2(gp_dec_factor) : 1;
   localparam logic [cnt_width-1:0] phase_last = cnt_width'(gp_dec_factor - 1);
   localparam logic [cnt_width-1:0] phase_keep = cnt_width'(gp_dec_phase);

   if (gp_lsb_drop < 0 || gp_oup_width < 2 || gp_lsb_drop + gp_oup_width > gp_inp_width) begin : g_bad_width
      $error("filt_dec_oup: need 0 <= gp_lsb_drop and gp_lsb_drop + gp_oup_width <= gp_inp_width");
   end
   if (gp_dec_factor < 1) begin : g_bad_factor
      $error("filt_dec_oup: gp_dec_factor must be >= 1");
   end
   if (gp_dec_phase < 0 || gp_dec_phase >= gp_dec_factor) begin : g_bad_phase
      $error("filt_dec_oup: gp_dec_phase must be in 0..gp_dec_factor-1");
   end

   logic [cnt_width-1:0]           phase_reg;
   logic [cnt_width-1:0]           phase_next;
   logic                           keep;
   logic signed [rnd_width-1:0]    rnd_next;
   logic signed [rnd_width-1:0]    rnd_reg;
   logic                           vld1_reg;
   logic signed [gp_oup_width-1:0] sat_data;
   logic                           sat_clip;
   logic signed [gp_oup_width-1:0] data_reg;
   logic                           valid_reg;
   logic                           ovf_reg;

   always_comb begin
      keep       = i_ena && (phase_reg == phase_keep);
      phase_next = phase_reg;
      if (i_ena) begin
         phase_next = (phase_reg == phase_last) ? '0 : phase_reg + 1'b1;
      end
   end

   // One extra bit of headroom means the rounding bias can never wrap.
   assign rnd_next = rnd_width'(rnd_half_up(wide_t'(i_data), gp_lsb_drop));

   dsp_rnd_sat #(
      .gp_inp_width (rnd_width),
      .gp_oup_width (gp_oup_width),
      .gp_lsb_drop  (0)
   ) u_sat (
      .i_data (rnd_reg),
      .o_data (sat_data),
      .o_ovf  (sat_clip)
   );

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         phase_reg <= '0;
         rnd_reg   <= '0;
         vld1_reg  <= 1'b0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         vld1_reg  <= keep;
         if (keep) begin
            rnd_reg <= rnd_next;
         end
         valid_reg <= vld1_reg;
         if (vld1_reg) begin
            data_reg <= sat_data;
         end
         // A new clamp outranks a simultaneous clear request.
         if (vld1_reg && sat_clip) begin
            ovf_reg <= 1'b1;
         end else if (i_clr_ovf) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   assign o_data  = data_reg;
   assign o_valid = valid_reg;
   assign o_ovf   = ovf_reg;

endmodule

// File: doc/filt_dec_oup.md
# filt_dec_oup

Output conditioning stage placed directly downstream of `filt_fir`. It takes the FIR's full-precision signed output and decimates it by an integer factor. Each kept sample is rounded (round-half-up) to drop LSBs and then saturated to the output width. The block produces a one-cycle valid strobe per output sample and a sticky overflow flag for the next rate domain.

## Interface
Parameters:
- `gp_inp_width`, 24, signed input width (FIR `o_data` width)
- `gp_oup_width`, 16, signed output width
- `gp_lsb_drop`, 6, LSBs removed by rounding; `gp_lsb_drop + gp_oup_width <= gp_inp_width`
- `gp_dec_factor`, 4, decimation factor M, >= 1
- `gp_dec_phase`, 0, kept phase, 0..M-1

Ports:
- `i_clk` in 1: single clock, rising edge.
- `i_rst_an` in 1: reset, asynchronous, active-low.
- `i_ena` in 1: input sample enable. Input is accepted on edges where this is 1.
- `i_data` in `gp_inp_width`: signed FIR output.
- `i_clr_ovf` in 1: synchronous clear of `o_ovf`.
- `o_data` out `gp_oup_width`: signed decimated result. Holds its value between strobes.
- `o_valid` out 1: one-cycle strobe marking new `o_data`.
- `o_ovf` out 1: sticky saturation flag.

## Operation
- Phase counter, 0..M-1:
  - Increments on each accepted sample and wraps from M-1 to 0.
  - Frozen while `i_ena=0`.
- Keep decision: an accepted sample whose counter value equals `gp_dec_phase` is kept. All other samples are discarded.
- Rounding:
  - Sign-extend the input by 1 bit.
  - Add 2^(`gp_lsb_drop`-1), then arithmetic-shift right by `gp_lsb_drop`.
  - If `gp_lsb_drop=0`, pass the value through unchanged.
  - Result width is `gp_inp_width - gp_lsb_drop + 1`. The add never wraps.
- Saturation:
  - Rounded value > 2^(`gp_oup_width`-1)-1 → clamp to the max.
  - Rounded value < -2^(`gp_oup_width`-1) → clamp to the min.
  - A clamp on a kept sample sets `o_ovf`.
- `o_ovf` behaviour:
  - Cleared by `i_clr_ovf=1`.
  - If a set and `i_clr_ovf` occur on the same edge, set wins.
- M=1: every accepted sample is output.
- Elaboration-time assertions cover the parameter constraints listed above.

## Timing
- Pipeline:
  - Stage 1 registers the rounded value plus a valid bit at the edge where the sample is accepted (edge k).
  - Stage 2 registers the saturated value into `o_data`, and the valid bit into `o_valid`, at edge k+1.
  - Latency: `o_valid=1` for the single cycle between edges k+1 and k+2.
- The pipeline advances every clock regardless of `i_ena`. Non-kept samples and cycles with `i_ena=0` insert valid=0 bubbles.
- `o_data` changes only when `o_valid` is asserted.
- `o_ovf` rises on the same edge as the `o_valid` of the clamped sample.
- Reset (asynchronous, any time), all to 0: `o_data`, `o_valid`, `o_ovf`, stage-1 registers, phase counter.
  - In-flight samples are discarded.
  - The first sample accepted after deassertion is phase 0.
- Max output rate is one strobe per M enabled cycles. There is no back-pressure.

## Structure
- `filt_pkg`:
  - rounding and saturation helper functions, parameterised by width
  - the `gp_*` default constants shared with `filt_fir`
- Sub-module `dsp_rnd_sat`: combinational round plus saturate, with an overflow output. It is reusable by other filters.
- `filt_dec_oup` contains:
  - the phase counter
  - both pipeline registers
  - the sticky flag logic

## Test plan
All scenarios use the defaults: inp 24, oup 16, lsb_drop 6, M=4, phase 0.
- Rounding, with M=1:
  - input 96 → 2
  - input 95 → 1
  - input -96 → -1
  - input -97 → -2
  - each on `o_valid` 2 edges after acceptance
- Saturation:
  - 2097120 → 32767 with `o_ovf`=1 (rounding pushes it to 32768).
  - -4194304 → -32768 with `o_ovf`=1.
  - 2097119 → 32767 with `o_ovf`=0.
- Decimation: ramp 0, 64, 128, … with `i_ena` held at 1.
  - Outputs are 0, 4, 8, … with `o_valid` every 4th cycle.
  - The first strobe is 2 edges after the first accepted sample.
- Enable gaps:
  - Deassert `i_ena` for 3 cycles mid-ramp.
  - The counter freezes and no samples are skipped.
  - Output values stay 0, 4, 8, …, with strobe spacing stretched by 3 cycles.
- Reset mid-stream:
  - Pull `i_rst_an` low with the counter at 2 and a sample in flight.
  - All outputs go to 0 immediately and no strobe is emitted.
  - The first sample after release is kept.
- Overflow clear:
  - Set `o_ovf`, then pulse `i_clr_ovf` → `o_ovf` reads 0 after that edge.
  - Assert `i_clr_ovf` on the same edge as a clamped strobe → `o_ovf` stays 1.
